// File: rtl/pwm_pkg.sv
// Shared types and frame-geometry helpers for the PWM capture path.
package pwm_pkg;

   typedef enum logic [1:0] {
      IDLE,
      HIGH,
      LOW
   } state_t;

   function automatic int unsigned pwm_period(input int unsigned w);
      return 32'd1 << w;
   endfunction

   function automatic int unsigned pwm_mid(input int unsigned w);
      return 32'd1 << (w - 32'd1);
   endfunction

endpackage

// File: rtl/pwm_in_sync.sv
// Synchroniser chain for the asynchronous PWM line plus a registered edge detector.
module pwm_in_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk_in,
   input  logic rstn,
   input  logic pwm_in,
   output logic s_in,
   output logic s_rise,
   output logic s_fall
);

   logic [SYNC_STAGES-1:0] sync_q;

   // s_in, s_rise and s_fall come from the same flop stage so they always agree.
   always_ff @(posedge clk_in or negedge rstn) begin
      if (!rstn) begin
         sync_q <= '0;
         s_in   <= 1'b0;
         s_rise <= 1'b0;
         s_fall <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
         s_in   <= sync_q[SYNC_STAGES-1];
         s_rise <= sync_q[SYNC_STAGES-1] & ~s_in;
         s_fall <= ~sync_q[SYNC_STAGES-1] & s_in;
      end
   end

endmodule

// File: rtl/pwm_capture.sv
// PWM input demodulator: measures high time and period per frame and recovers signed
// samples, flagging saturated frames, malformed periods and a silent link.
module pwm_capture
   import pwm_pkg::*;
#(
   parameter int unsigned DATA_OUT_WIDTH = 10,
   parameter int unsigned SYNC_STAGES    = 2
) (
   input  logic                             clk_in,
   input  logic                             rstn,
   input  logic                             cap_en,
   input  logic                             PWM_IN,
   output logic signed [DATA_OUT_WIDTH-1:0] data_out,
   output logic                             data_valid,
   output logic                             sat_high,
   output logic                             period_err,
   output logic                             link_idle
);

   localparam int unsigned W       = DATA_OUT_WIDTH;
   localparam logic [W:0]  PERIOD  = (W+1)'(pwm_period(W));
   localparam logic [W:0]  ONE     = (W+1)'(1);
   localparam logic [W-1:0] OFFSET  = W'(pwm_mid(W) + 32'd1);
   localparam logic [W-1:0] MAX_POS = W'(pwm_mid(W) - 32'd1);

   logic         s_in;
   logic         s_rise;
   logic         s_fall;
   state_t       state;
   logic [W:0]   high_cnt;
   logic [W:0]   period_cnt;
   logic [W-1:0] sample;

   pwm_in_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .clk_in(clk_in),
      .rstn  (rstn),
      .pwm_in(PWM_IN),
      .s_in  (s_in),
      .s_rise(s_rise),
      .s_fall(s_fall)
   );

   // High time of s + MID + 1 maps back to s; modulo-2^W arithmetic gives the sign.
   assign sample = high_cnt[W-1:0] - OFFSET;

   always_ff @(posedge clk_in or negedge rstn) begin
      if (!rstn) begin
         state      <= IDLE;
         high_cnt   <= '0;
         period_cnt <= '0;
         data_out   <= '0;
         data_valid <= 1'b0;
         sat_high   <= 1'b0;
         period_err <= 1'b0;
         link_idle  <= 1'b1;
      end else begin
         data_valid <= 1'b0;
         period_err <= 1'b0;
         if (!cap_en) begin
            state      <= IDLE;
            high_cnt   <= '0;
            period_cnt <= '0;
            sat_high   <= 1'b0;
            link_idle  <= 1'b1;
         end else begin
            unique case (state)
               IDLE: begin
                  if (s_rise) begin
                     state      <= HIGH;
                     high_cnt   <= ONE;
                     period_cnt <= ONE;
                     link_idle  <= 1'b0;
                  end
               end
               HIGH: begin
                  if (s_fall) begin
                     state <= LOW;
                     if (period_cnt != PERIOD) period_cnt <= period_cnt + ONE;
                  end else if (s_in) begin
                     if (high_cnt == PERIOD) begin
                        // A whole period high: report full scale and start a new frame.
                        data_out   <= $signed(MAX_POS);
                        sat_high   <= 1'b1;
                        data_valid <= 1'b1;
                        high_cnt   <= ONE;
                        period_cnt <= ONE;
                     end else begin
                        high_cnt <= high_cnt + ONE;
                        if (period_cnt != PERIOD) period_cnt <= period_cnt + ONE;
                     end
                  end
               end
               LOW: begin
                  if (s_rise) begin
                     if (period_cnt == PERIOD) begin
                        data_out   <= $signed(sample);
                        data_valid <= 1'b1;
                        sat_high   <= 1'b0;
                     end else begin
                        period_err <= 1'b1;
                     end
                     state      <= HIGH;
                     high_cnt   <= ONE;
                     period_cnt <= ONE;
                  end else if (period_cnt == PERIOD) begin
                     state     <= IDLE;
                     link_idle <= 1'b1;
                  end else begin
                     period_cnt <= period_cnt + ONE;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: a randomized PWM waveform scored against a frame-level model,
// then directed cap_en and reset scenarios.
module tb_pwm_capture;

   localparam int PER = 1024;
   localparam int MID = 512;
   localparam int LAT = 4;

   localparam int EV_NONE  = 0;
   localparam int EV_VALID = 1;
   localparam int EV_SAT   = 2;
   localparam int EV_ERR   = 3;
   localparam int EV_IDLE  = 4;
   localparam int EV_LINK  = 5;

   logic              clk_in = 1'b0;
   logic              rstn   = 1'b0;
   logic              cap_en = 1'b1;
   logic              pwm_line = 1'b0;
   logic signed [9:0] data_out;
   logic              data_valid;
   logic              sat_high;
   logic              period_err;
   logic              link_idle;

   int checks = 0;
   int errors = 0;
   int cyc_no = 0;
   int vcount = 0;
   int ecount = 0;
   int last_valid = -1;

   bit lvl_q[$];
   int ev_kind[];
   int ev_data[];

   pwm_capture #(
      .DATA_OUT_WIDTH(10),
      .SYNC_STAGES   (2)
   ) dut (
      .clk_in    (clk_in),
      .rstn      (rstn),
      .cap_en    (cap_en),
      .PWM_IN    (pwm_line),
      .data_out  (data_out),
      .data_valid(data_valid),
      .sat_high  (sat_high),
      .period_err(period_err),
      .link_idle (link_idle)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic add(input bit lv, input int n);
      for (int i = 0; i < n; i++) lvl_q.push_back(lv);
   endtask

   task automatic frame(input int h, input int p);
      add(1'b1, h);
      add(1'b0, p - h);
   endtask

   // Outputs react LAT cycles after the line level that causes them.
   task automatic note(input int idx, input int kind, input int data);
      if (idx + LAT < ev_kind.size()) begin
         ev_kind[idx + LAT] = kind;
         ev_data[idx + LAT] = data;
      end
   endtask

   // Walks the waveform frame by frame: f is the start of the current frame.
   task automatic build_model();
      int  n;
      int  f;
      int  t;
      bit  linked;
      bit  done;
      n = lvl_q.size();
      ev_kind = new[n];
      ev_data = new[n];
      f = 0;
      t = 0;
      linked = 1'b0;
      done = 1'b0;
      while (!done && t < n) begin
         if (!linked) begin
            int r;
            r = -1;
            for (int i = t; i < n; i++) begin
               if (lvl_q[i] && (i == 0 || !lvl_q[i-1])) begin
                  r = i;
                  break;
               end
            end
            if (r < 0) done = 1'b1;
            else begin
               note(r, EV_LINK, 0);
               f = r;
               linked = 1'b1;
            end
         end else if (f + PER >= n) begin
            done = 1'b1;
         end else begin
            int fl;
            int r;
            fl = -1;
            r = -1;
            for (int i = f + 1; i <= f + PER; i++) begin
               if (!lvl_q[i]) begin
                  fl = i;
                  break;
               end
            end
            if (fl < 0) begin
               note(f + PER, EV_SAT, MID - 1);
               f = f + PER;
            end else begin
               for (int i = fl + 1; i <= f + PER; i++) begin
                  if (lvl_q[i]) begin
                     r = i;
                     break;
                  end
               end
               if (r < 0) begin
                  note(f + PER, EV_IDLE, 0);
                  linked = 1'b0;
                  t = f + PER + 1;
               end else begin
                  if (r - f == PER) note(r, EV_VALID, (fl - f) - 1 - MID);
                  else note(r, EV_ERR, 0);
                  f = r;
               end
            end
         end
      end
   endtask

   task automatic cyc(input bit lv, input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk_in);
         #2 pwm_line = lv;
         @(negedge clk_in);
         if (data_valid) begin
            vcount++;
            last_valid = cyc_no;
         end
         if (period_err) ecount++;
         cyc_no++;
      end
   endtask

   initial begin
      logic signed [9:0] e_data;
      logic              e_valid;
      logic              e_sat;
      logic              e_err;
      logic              e_link;
      int                r0;
      int                r1;
      int                r2;
      int                r3;
      int                vbase;

      // Reset values
      repeat (3) @(negedge clk_in);
      chk("rst_data", 32'(data_out), 32'd0);
      chk("rst_valid", 32'(data_valid), 32'd0);
      chk("rst_sat", 32'(sat_high), 32'd0);
      chk("rst_err", 32'(period_err), 32'd0);
      chk("rst_idle", 32'(link_idle), 32'd1);
      rstn = 1'b1;

      // Waveform: zero, both extremes, saturated run, idle gap, short frame, random frames
      add(1'b0, 20);
      repeat (3) frame(513, PER);
      repeat (2) frame(1, PER);
      repeat (2) frame(1023, PER);
      add(1'b1, 3 * PER + 300);
      add(1'b0, 3000);
      repeat (2) frame(513, PER);
      frame(400, 1000);
      repeat (2) frame(600, PER);
      for (int k = 0; k < 16; k++) begin
         int h;
         int p;
         int sel;
         h = int'($urandom_range(1, 1023));
         sel = int'($urandom_range(0, 7));
         if (sel == 0 && h < 1000) p = int'($urandom_range(unsigned'(h + 1), 1023));
         else if (sel == 1) p = PER + int'($urandom_range(1, 300));
         else p = PER;
         frame(h, p);
      end
      frame(513, PER);
      add(1'b0, 1200);
      build_model();

      e_data = '0;
      e_sat  = 1'b0;
      e_link = 1'b1;
      for (int c = 0; c < lvl_q.size(); c++) begin
         @(posedge clk_in);
         #2 pwm_line = lvl_q[c];
         @(negedge clk_in);
         e_valid = 1'b0;
         e_err   = 1'b0;
         case (ev_kind[c])
            EV_VALID: begin
               e_valid = 1'b1;
               e_data  = 10'(ev_data[c]);
               e_sat   = 1'b0;
            end
            EV_SAT: begin
               e_valid = 1'b1;
               e_data  = 10'(ev_data[c]);
               e_sat   = 1'b1;
            end
            EV_ERR:  e_err = 1'b1;
            EV_IDLE: e_link = 1'b1;
            EV_LINK: e_link = 1'b0;
            default: ;
         endcase
         chk($sformatf("run_c%0d{data,valid,sat,err,idle}", c),
             32'({data_out, data_valid, sat_high, period_err, link_idle}),
             32'({e_data, e_valid, e_sat, e_err, e_link}));
      end

      // cap_en dropped mid-frame
      vcount = 0;
      ecount = 0;
      r0 = cyc_no;
      cyc(1'b1, 700);
      cyc(1'b0, 324);
      cyc(1'b1, 700);
      cyc(1'b0, 324);
      cyc(1'b1, 300);
      chk("cap_vcount", 32'(vcount), 32'd2);
      chk("cap_last_valid", 32'(last_valid), 32'(r0 + 2 * PER + LAT));
      chk("cap_data", 32'(data_out), 32'(187));
      chk("cap_link", 32'(link_idle), 32'd0);
      cap_en = 1'b0;
      cyc(1'b1, 2);
      chk("capoff_link", 32'(link_idle), 32'd1);
      chk("capoff_data_hold", 32'(data_out), 32'(187));
      chk("capoff_sat", 32'(sat_high), 32'd0);
      cyc(1'b1, 98);
      cyc(1'b0, 324);
      cyc(1'b1, 700);
      cyc(1'b0, 100);
      cap_en = 1'b1;
      cyc(1'b0, 224);
      chk("capoff_no_valid", 32'(vcount), 32'd2);
      chk("capoff_no_err", 32'(ecount), 32'd0);
      chk("capoff_link_hold", 32'(link_idle), 32'd1);
      r1 = cyc_no;
      cyc(1'b1, 300);
      cyc(1'b0, 724);
      r2 = cyc_no;
      cyc(1'b1, 200);
      chk("recap_vcount", 32'(vcount), 32'd3);
      chk("recap_last_valid", 32'(last_valid), 32'(r1 + PER + LAT));
      chk("recap_data", 32'(data_out), 32'(-213));
      chk("recap_link", 32'(link_idle), 32'd0);
      cyc(1'b1, 2000);
      chk("sat_vcount", 32'(vcount), 32'd5);
      chk("sat_last_valid", 32'(last_valid), 32'(r2 + 2 * PER + LAT));
      chk("sat_data", 32'(data_out), 32'(511));
      chk("sat_flag", 32'(sat_high), 32'd1);

      // Reset pulsed mid-HIGH, released while the line is low
      @(posedge clk_in);
      #3 rstn = 1'b0;
      @(negedge clk_in);
      chk("midrst_data", 32'(data_out), 32'd0);
      chk("midrst_valid", 32'(data_valid), 32'd0);
      chk("midrst_sat", 32'(sat_high), 32'd0);
      chk("midrst_err", 32'(period_err), 32'd0);
      chk("midrst_link", 32'(link_idle), 32'd1);
      cyc(1'b1, 20);
      cyc(1'b0, 100);
      rstn = 1'b1;
      cyc(1'b0, 200);
      vbase = vcount;
      r3 = cyc_no;
      cyc(1'b1, 513);
      cyc(1'b0, 511);
      cyc(1'b1, 513);
      chk("post_rst_vcount", 32'(vcount), 32'(vbase + 1));
      chk("post_rst_last_valid", 32'(last_valid), 32'(r3 + PER + LAT));
      chk("post_rst_data", 32'(data_out), 32'd0);
      chk("post_rst_err", 32'(ecount), 32'd0);
      chk("post_rst_link", 32'(link_idle), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pwm_capture.md
# pwm_capture

PWM input demodulator for the baseband path. It recovers signed samples from a free-running PWM stream, i.e. the receive end of the `pwm` DAC output.

- **Input stream:** a PWM of period 2^W clock cycles, where a signed sample s is sent as a high time of s + 2^(W-1) + 1 cycles.
- **Recovery:** the block synchronises the stream, measures high time and period per frame, and checks each period.
- **Output:** a validated signed sample per period, with status flags for saturation, period error and idle link.

## Interface
Parameters:
- `DATA_OUT_WIDTH`, default 10: sample width W. The expected period is 2^W cycles.
- `SYNC_STAGES`, default 2: number of input synchroniser flops, minimum 2.

Ports:
- `clk_in`, input, 1: single clock, shared with the transmitter.
- `rstn`, input, 1: reset, asynchronous and active-low.
- `cap_en`, input, 1: capture enable. Low forces IDLE.
- `PWM_IN`, input, 1: asynchronous PWM line.
- `data_out`, output, signed W: last recovered sample, registered.
- `data_valid`, output, 1: one-cycle pulse when `data_out` updates.
- `sat_high`, output, 1: the last sample came from a full-period-high frame (s = 2^(W-1)-1).
- `period_err`, output, 1: one-cycle pulse when a measured period ≠ 2^W.
- `link_idle`, output, 1: no valid rising edge within the timeout window.

## Operation
- **Synchroniser:** `PWM_IN` passes through `SYNC_STAGES` flops, then one edge-detect flop. The FSM acts only on the synchronised level `s_in`, rise `s_rise` and fall `s_fall`.
- **Counters:** `high_cnt` and `period_cnt` are W+1 bits wide and never wrap. Both saturate at 2^W.
- **States:** IDLE, HIGH, LOW.
- **IDLE:**
  - `s_rise` → HIGH, with `high_cnt`=1 and `period_cnt`=1.
  - The first rise never produces `data_valid`; a full period is required first.
  - `link_idle` clears on this rise.
- **HIGH:** each cycle with `s_in`=1, increment both counters.
  - `s_fall` → LOW, with `period_cnt` incremented.
  - `high_cnt` reaching 2^W while still high is a saturated frame:
    - `data_out` = 2^(W-1)-1, `sat_high`=1, `data_valid` pulse.
    - Reload both counters to 1 and stay in HIGH.
- **LOW:** each low cycle increments `period_cnt`.
  - `s_rise` with `period_cnt` = 2^W:
    - `data_out` = (`high_cnt` − 1 − 2^(W-1)), truncated to W bits, giving a range of −2^(W-1) to 2^(W-1)−2.
    - `data_valid` pulse, `sat_high`=0.
  - `s_rise` with `period_cnt` ≠ 2^W:
    - `period_err` pulse; no valid, and `data_out` holds.
  - Either way, reload counters to 1 and go to HIGH.
  - Low persisting with `period_cnt` = 2^W and `s_in` still 0 on the next cycle → IDLE with `link_idle`=1. `data_out` holds.
- **Simultaneous events:** `s_rise` and `s_fall` are mutually exclusive by construction. A timeout and a rise in the same cycle are decided in favour of the rise.
- **`cap_en` low:**
  - FSM goes to IDLE and counters clear.
  - `data_valid`, `period_err` and `sat_high` are forced to 0.
  - `link_idle`=1 and `data_out` holds.
  - The synchroniser keeps running.

## Timing
- **Reset values:**
  - `data_out`=0, `data_valid`=0, `sat_high`=0, `period_err`=0, `link_idle`=1.
  - FSM in IDLE, counters 0, synchroniser flops 0.
- **Latency:** `data_valid`/`period_err` assert SYNC_STAGES+2 clocks after the `PWM_IN` rising edge that closes the period.
  - `data_out`, `sat_high` and `data_valid` update in the same cycle.
- **Throughput:** at most one `data_valid` per 2^W cycles.
- **Reset mid-frame:** immediate return to reset values. The first valid arrives one full period after the first post-reset rise.
- **No backpressure:** the consumer must sample on `data_valid`.

## Structure
- **Package `pwm_pkg`:**
  - State enum: IDLE, HIGH, LOW.
  - Functions/constants for PERIOD = 2^W and MID = 2^(W-1).
- **Sub-module `pwm_in_sync`:** synchroniser chain plus edge detect. It outputs `s_in`, `s_rise` and `s_fall`.
- The FSM, counters and output registers live in `pwm_capture`.

## Test plan
All scenarios use W=10, SYNC_STAGES=2, with `pwm` driving `PWM_IN`.

1. `pwm` `data_in`=0, `pwm_en`=1 (high time 513) → after the first full period, `data_out`=0 with `data_valid` every 1024 cycles; `sat_high`=0, `period_err`=0.
2. `data_in`=−512 (high time 1) → `data_out`=−512. Then `data_in`=510 → `data_out`=510 on the following valid.
3. `data_in`=511 (constant high) → `data_out`=511, `sat_high`=1, `data_valid` every 1024 cycles, `link_idle`=0.
4. `pwm_en`=0 for 3000 cycles → `link_idle`=1 1025 cycles after the last rise, with no valid. Re-enable → `link_idle` clears at the first rise; first valid follows 1024 cycles later.
5. Injected frame with a 1000-cycle period → `period_err` pulse, no `data_valid`, `data_out` unchanged. The next correct frame produces a valid.
6. `rstn` pulsed mid-HIGH, and `cap_en` dropped mid-frame → all outputs return to reset values. Capture resumes with the first valid one full period after the next rise.
